// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: byte-level I2C master. Accepts START/WRITE/READ/STOP
// commands, drives SCL/SDA from a quarter-bit divider and returns one
// response pulse per command with received byte and ACK status.
module i2c_bit_engine #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] tx_byte_i,
  input  logic       rx_ack_send_i,
  output logic       rsp_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       ack_received_o,
  output logic       cmd_err_o,
  output logic       busy_o,
  output logic       bus_active_o,
  output logic       scl_o,
  output logic       sda_oe_o,
  input  logic       sda_in_i
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [1:0] C_START = 2'd0, C_WRITE = 2'd1, C_READ = 2'd2, C_STOP = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [3:0]      slot_q, slot_d;
  logic            rd_q, rd_d;
  logic            ack_send_q, ack_send_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            scl_q, scl_d;
  logic            oe_q, oe_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            bus_q, bus_d;
  logic            rel_q, rel_d;   // one-cycle flag: release SDA in DONE after a byte
  logic            tick;
  logic            ready;

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign tick  = (state_q == S_START || state_q == S_BIT || state_q == S_STOP) &&
                 (cnt_q == CW'(CLK_DIV - 1));

  // Next-state, quarter actions and command accept
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qtr_d      = qtr_q;
    slot_d     = slot_q;
    rd_d       = rd_q;
    ack_send_d = ack_send_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_byte_d  = rx_byte_q;
    scl_d      = scl_q;
    oe_d       = oe_q;
    ack_d      = ack_q;
    err_d      = err_q;
    bus_d      = bus_q;
    rel_d      = 1'b0;

    unique case (state_q)
      S_START, S_BIT, S_STOP: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (state_q == S_START) begin
            unique case (qtr_q)
              2'd0: scl_d = 1'b1;
              2'd1: oe_d  = 1'b1;            // SDA falls with SCL high
              2'd2: scl_d = 1'b0;
              2'd3: state_d = S_DONE;
            endcase
          end else if (state_q == S_STOP) begin
            unique case (qtr_q)
              2'd0: scl_d = 1'b1;
              2'd1: oe_d  = 1'b0;            // SDA rises with SCL high
              2'd2: ;                        // Q3 hold
              2'd3: begin
                state_d = S_DONE;
                bus_d   = 1'b0;
              end
            endcase
          end else begin
            unique case (qtr_q)
              2'd0: scl_d = 1'b1;
              2'd1: begin                    // mid-high sample point
                if (rd_q && slot_q < 4'd8) rx_sh_d = {rx_sh_q[6:0], sda_in_i};
                if (!rd_q && slot_q == 4'd8) ack_d = ~sda_in_i;
              end
              2'd2: scl_d = 1'b0;
              2'd3: begin
                if (slot_q == 4'd8) begin
                  state_d = S_DONE;
                  rel_d   = 1'b1;
                  if (rd_q) rx_byte_d = rx_sh_q;
                end else begin
                  slot_d = slot_q + 4'd1;
                  tx_d   = {tx_q[6:0], 1'b0};
                  scl_d  = 1'b0;
                  oe_d   = (slot_q == 4'd7) ? (rd_q & ack_send_q) : (~rd_q & ~tx_q[6]);
                end
              end
            endcase
          end
        end
      end
      default: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
          if (rel_q) oe_d = 1'b0;
        end
        if (cmd_valid_i) begin
          cnt_d      = '0;
          qtr_d      = 2'd0;
          slot_d     = 4'd0;
          ack_d      = 1'b0;
          err_d      = 1'b0;
          rd_d       = (cmd_i == C_READ);
          tx_d       = tx_byte_i;
          ack_send_d = rx_ack_send_i;
          unique case (cmd_i)
            C_START: begin
              state_d = S_START;
              bus_d   = 1'b1;
              oe_d    = 1'b0;
            end
            C_WRITE, C_READ: begin
              if (bus_q) begin
                state_d = S_BIT;
                scl_d   = 1'b0;
                oe_d    = (cmd_i == C_WRITE) & ~tx_byte_i[7];
              end else begin
                state_d = S_DONE;
                err_d   = 1'b1;
              end
            end
            C_STOP: begin
              if (bus_q) begin
                state_d = S_STOP;
                scl_d   = 1'b0;
                oe_d    = 1'b1;
              end else begin
                state_d = S_DONE;
                err_d   = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      qtr_q      <= 2'd0;
      slot_q     <= 4'd0;
      rd_q       <= 1'b0;
      ack_send_q <= 1'b0;
      tx_q       <= 8'h00;
      rx_sh_q    <= 8'h00;
      rx_byte_q  <= 8'h00;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      bus_q      <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      slot_q     <= slot_d;
      rd_q       <= rd_d;
      ack_send_q <= ack_send_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      scl_q      <= scl_d;
      oe_q       <= oe_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      bus_q      <= bus_d;
      rel_q      <= rel_d;
    end
  end

  assign cmd_ready_o    = ready;
  assign busy_o         = ~ready;
  assign rsp_valid_o    = (state_q == S_DONE);
  assign rx_byte_o      = rx_byte_q;
  assign ack_received_o = ack_q;
  assign cmd_err_o      = err_q;
  assign bus_active_o   = bus_q;
  assign scl_o          = scl_q;
  assign sda_oe_o       = oe_q;
endmodule
